// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The state enum and clog2 helper are used by uart_rx and sync_fifo.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Number of bits needed to index 'value' entries (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with one extra pointer bit to separate full from empty.
// A push while full is accepted only if a pop frees the head slot on the same edge.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // Head reads as zero while empty so reset leaves the output port at 0.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and a receive FIFO.
// Decoded bytes leave through a valid/ready port; framing and overrun are pulsed.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int              CW       = clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic            rx_meta;
    logic            rx_s;
    rx_state_t       state;
    rx_state_t       state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_d;
    logic [7:0]      shreg;
    logic [7:0]      shreg_d;
    logic            push_req;
    logic            frame_err_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    // Flops preset high so reset looks like an idle line, not a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            shreg     <= shreg_d;
            frame_err <= frame_err_d;
            overrun   <= push_req && fifo_full && !pop;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_idx_d   = bit_idx;
        shreg_d     = shreg;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (!rx_s) begin
                    cnt_d     = CNT_FULL;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    shreg_d[bit_idx] = rx_s;
                    cnt_d            = CNT_FULL;
                    if (bit_idx == LAST_BIT) state_d = STOP;
                    else                     bit_idx_d = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    push_req    = rx_s;
                    frame_err_d = !rx_s;
                    state_d     = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Hold here until the line recovers so a long break flags only once.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake: a byte leaves on every rising edge where out_valid and out_ready
    // are both high; out_data holds the head byte steady until that edge.
    assign pop       = out_ready && !fifo_empty;
    assign out_valid = !fifo_empty;
    assign busy      = (state != IDLE);

    sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   (shreg),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit and the
// popped bytes, pulses and timing are compared against expectations built here.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 2 + (19 * CPB) / 2 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        errors = errors + 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard / monitor ----------------
    logic [7:0]  pop_q[$];
    logic [7:0]  exp_q[$];
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          rise_cnt = 0;
    int          vcnt = 0;
    int unsigned ov_cyc = 0;
    int unsigned rise_cyc = 0;
    int unsigned last_start = 0;
    logic        prev_valid = 1'b0;
    bit          rand_ready = 1'b0;

    always @(negedge clk) begin
        if (out_valid && out_ready) pop_q.push_back(out_data);
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun) begin
            ov_cnt = ov_cnt + 1;
            ov_cyc = cyc;
        end
        if (out_valid) vcnt = vcnt + 1;
        if (out_valid && !prev_valid) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        prev_valid = out_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    // One 8N1 frame: start, 8 data bits LSB first, stop at stop_lvl for stop_len clocks.
    // pop_at >= 0 raises out_ready only on that clock; abort_at >= 0 asserts reset there.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len,
                              input int pop_at, input int abort_at);
        for (int t = 0; t < 9 * CPB + stop_len; t++) begin
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                return;
            end
            if (t == 0) last_start = cyc;
            if (t < CPB)          rx = 1'b0;
            else if (t < 9 * CPB) rx = d[(t / CPB) - 1];
            else                  rx = stop_lvl;
            if (pop_at >= 0)      out_ready = (t == pop_at);
            else if (rand_ready)  out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rx = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) tick();
        out_ready = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_single();
        int r0, f0, o0;
        pop_q.delete();
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        out_ready = 1'b1;
        vcnt = 0;
        send_frame(8'hA5, 1'b1, CPB, -1, -1);
        idle(10);
        checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL single_rises got %0d exp 1", rise_cnt - r0); end
        checks++; if (rise_cyc - last_start != LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", rise_cyc - last_start, LAT); end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL single_valid_cycles got %0d exp 1", vcnt); end
        checks++; if (pop_q.size() != 1 || pop_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %0d bytes, first %h exp 1 byte a5", pop_q.size(), (pop_q.size() > 0) ? pop_q[0] : 8'hxx); end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL single_pulses got fe %0d ov %0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int o0;
        pop_q.delete();
        exp_q = '{8'h00, 8'hFF, 8'h55};
        o0 = ov_cnt;
        out_ready = 1'b0;
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, CPB, -1, -1);
        idle(5);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL b2b_head got v%b %h exp v1 00", out_valid, out_data); end
        checks++; if (pop_q.size() != 0) begin errors++; $display("FAIL b2b_early_pop got %0d exp 0", pop_q.size()); end
        drain();
        checks++; if (pop_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", pop_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
            checks++; if (pop_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, pop_q[i], exp_q[i]); end
        end
        checks++; if (ov_cnt != o0) begin errors++; $display("FAIL b2b_ov got %0d exp 0", ov_cnt - o0); end
    endtask

    task automatic test_overrun();
        int o0, f0;
        logic [7:0] sent[$];
        pop_q.delete();
        o0 = ov_cnt; f0 = fe_cnt;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sent.push_back(8'(i));
            send_frame(8'(i), 1'b1, CPB, -1, -1);
        end
        idle(5);
        checks++; if (ov_cnt - o0 != sent.size() - DEPTH) begin errors++; $display("FAIL ovr_count got %0d exp %0d", ov_cnt - o0, sent.size() - DEPTH); end
        checks++; if (ov_cyc - last_start != LAT) begin errors++; $display("FAIL ovr_time got %0d exp %0d", ov_cyc - last_start, LAT); end
        checks++; if (fe_cnt != f0) begin errors++; $display("FAIL ovr_fe got %0d exp 0", fe_cnt - f0); end
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(sent[i]);
        drain();
        checks++; if (pop_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_drain_count got %0d exp %0d", pop_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
            checks++; if (pop_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovr_byte%0d got %h exp %h", i, pop_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_pop();
        int o0;
        pop_q.delete();
        o0 = ov_cnt;
        out_ready = 1'b0;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h66};
        for (int i = 0; i < DEPTH; i++) send_frame(exp_q[i], 1'b1, CPB, -1, -1);
        idle(3);
        // Stop bit of this frame is sampled on clock LAT-1 after the start drive.
        send_frame(8'h66, 1'b1, CPB, LAT - 1, -1);
        out_ready = 1'b0;
        idle(5);
        checks++; if (ov_cnt != o0) begin errors++; $display("FAIL full_pop_ov got %0d exp 0", ov_cnt - o0); end
        checks++; if (pop_q.size() != 1 || pop_q[0] !== 8'h01) begin errors++; $display("FAIL full_pop_head got %0d bytes, first %h exp 1 byte 01", pop_q.size(), (pop_q.size() > 0) ? pop_q[0] : 8'hxx); end
        drain();
        checks++; if (pop_q.size() != exp_q.size()) begin errors++; $display("FAIL full_pop_count got %0d exp %0d", pop_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
            checks++; if (pop_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_pop_byte%0d got %h exp %h", i, pop_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_frame_err();
        int f0, r0;
        f0 = fe_cnt; r0 = rise_cnt;
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 40, -1, -1);
        rx = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_busy_low got %b exp 1", busy); end
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL fe_count got %0d exp 1", fe_cnt - f0); end
        rx = 1'b1;
        idle(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_busy_high got %b exp 0", busy); end
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL fe_push got %0d exp 0", rise_cnt - r0); end
        idle(4);
    endtask

    task automatic test_glitch();
        int f0, r0, drop_n;
        bit saw_busy;
        f0 = fe_cnt; r0 = rise_cnt;
        saw_busy = 1'b0;
        drop_n = -1;
        rx = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 3) rx = 1'b1;
            if (busy) saw_busy = 1'b1;
            if (saw_busy && !busy) begin
                drop_n = n;
                break;
            end
        end
        rx = 1'b1;
        checks++; if (!saw_busy) begin errors++; $display("FAIL glitch_busy got 0 exp 1"); end
        checks++; if (drop_n < 0 || drop_n > CPB / 2 + 3) begin errors++; $display("FAIL glitch_drop got %0d exp <= %0d", drop_n, CPB / 2 + 3); end
        idle(10);
        checks++; if (fe_cnt != f0 || rise_cnt != r0) begin errors++; $display("FAIL glitch_side got fe %0d push %0d exp 0 0", fe_cnt - f0, rise_cnt - r0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rb;
        rb = 8'($urandom_range(0, 255));
        out_ready = 1'b0;
        send_frame(rb, 1'b1, CPB, -1, -1);
        idle(3);
        checks++; if (out_valid !== 1'b1 || out_data !== rb) begin errors++; $display("FAIL rst_pre got v%b %h exp v1 %h", out_valid, out_data, rb); end
        // Reset lands in the middle of data bit 4.
        send_frame(8'h81, 1'b1, CPB, -1, 5 * CPB + CPB / 2);
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_out got v%b %h exp v0 00", out_valid, out_data); end
        checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got b%b f%b o%b exp 000", busy, frame_err, overrun); end
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        pop_q.delete();
        out_ready = 1'b1;
        send_frame(8'h7E, 1'b1, CPB, -1, -1);
        idle(10);
        checks++; if (pop_q.size() != 1 || pop_q[0] !== 8'h7E) begin errors++; $display("FAIL rst_next got %0d bytes, first %h exp 1 byte 7e", pop_q.size(), (pop_q.size() > 0) ? pop_q[0] : 8'hxx); end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int f0, o0;
        logic [7:0] b;
        pop_q.delete();
        exp_q.delete();
        f0 = fe_cnt; o0 = ov_cnt;
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, CPB, -1, -1);
            idle($urandom_range(0, 20));
        end
        rand_ready = 1'b0;
        drain();
        checks++; if (pop_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", pop_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++) begin
            checks++; if (pop_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h exp %h", i, pop_q[i], exp_q[i]); end
        end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL rand_pulses got fe %0d ov %0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_full_pop();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
